// File: rtl/fir_pkg.sv
// fir_pkg: widths, FSM state type, default coefficients and output saturation shared by fir_tap_sequencer.
package fir_pkg;
    localparam int NTAPS = 17;
    localparam int DW    = 8;
    localparam int CW    = 16;
    localparam int OW    = 10;
    localparam int ACCW  = 29;
    localparam int PW    = DW + CW;
    localparam int KW    = 5;
    localparam logic [KW-1:0] NTAPS_K = KW'(NTAPS);
    localparam logic [KW-1:0] LAST_K  = KW'(NTAPS - 1);
    localparam logic signed [ACCW-1:0] SAT_HI = ACCW'(2 ** (PW - 1) - 1);
    localparam logic signed [ACCW-1:0] SAT_LO = ~SAT_HI;
    localparam logic signed [CW-1:0] COEF_DEFAULT [NTAPS] = '{
        16'sd0, -16'sd2639, -16'sd3331, 16'sd0, 16'sd6747, 16'sd13535, 16'sd16384, 16'sd13535,
        16'sd6747, 16'sd0, -16'sd3331, -16'sd2639, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0
    };

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    // Clamp to the 24-bit product range, then keep the Q1.14 integer part (floor).
    function automatic logic signed [OW-1:0] sat_out(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] c;
        c = a > SAT_HI ? SAT_HI : (a < SAT_LO ? SAT_LO : a);
        return c[PW-1:PW-OW];
    endfunction
endpackage

// File: rtl/fir_tap_sequencer_if.sv
// fir_tap_sequencer_if: sample-in and result-out valid/ready handshakes of fir_tap_sequencer.
interface fir_tap_sequencer_if;
    import fir_pkg::*;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;

    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: coefficient store read combinationally by tap index.
// FIR_COEF_LOAD_EN adds a write port with reset to defaults; otherwise it is a constant ROM.
module fir_coef_bank
    import fir_pkg::*;
(
`ifdef FIR_COEF_LOAD_EN
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [4:0]           addr,
    input  logic signed [CW-1:0] data,
`endif
    input  logic [KW-1:0]        k,
    output logic signed [CW-1:0] coef
);
`ifdef FIR_COEF_LOAD_EN
    logic signed [CW-1:0] mem [NTAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) mem[i] <= COEF_DEFAULT[i];
        end else if (we && addr < NTAPS_K) begin
            mem[addr] <= data;
        end
    end

    assign coef = k < NTAPS_K ? mem[k] : '0;
`else
    assign coef = k < NTAPS_K ? COEF_DEFAULT[k] : '0;
`endif
endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: 17-tap FIR sharing one multiplier and accumulator, one tap per cycle.
// FIR_COEF_LOAD_EN exposes runtime coefficient writes accepted only while idle.
module fir_tap_sequencer
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    fir_tap_sequencer_if.slave   bus,
`ifdef FIR_COEF_LOAD_EN
    input  logic                 coef_we,
    input  logic [4:0]           coef_addr,
    input  logic signed [CW-1:0] coef_data,
`endif
    output logic                 busy
);
    state_t state, state_nx;
    logic run, accept, last;
    logic [KW-1:0] k, wr_ptr, rd_idx;
    logic signed [DW-1:0] sbuf [NTAPS];
    logic signed [CW-1:0] coef;
    logic signed [PW-1:0] prod;
    logic signed [ACCW-1:0] acc, acc_nx;

    fir_coef_bank u_coef (
`ifdef FIR_COEF_LOAD_EN
        .clk   (clk),
        .rst_n (rst_n),
        .we    (coef_we && state == IDLE),
        .addr  (coef_addr),
        .data  (coef_data),
`endif
        .k     (k),
        .coef  (coef)
    );

    assign accept       = bus.in_valid && bus.in_ready;
    assign last         = state == MAC && k == LAST_K;
    // Tap k reads the sample k steps older than the newest, walking backwards around the ring.
    assign rd_idx       = wr_ptr >= k ? wr_ptr - k : wr_ptr + NTAPS_K - k;
    assign prod         = PW'(coef) * PW'(sbuf[rd_idx]);
    assign acc_nx       = acc + ACCW'(prod);
    // run keeps in_ready low until the first edge after reset release.
    assign bus.in_ready  = run && state == IDLE;
    assign bus.out_valid = state == OUT;
    assign busy          = state != IDLE;

    always_comb begin
        state_nx = accept ? MAC : last ? OUT : (state == OUT && bus.out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            run   <= 1'b0;
        end else begin
            state <= state_nx;
            run   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) sbuf[i] <= '0;
            acc          <= '0;
            k            <= '0;
            wr_ptr       <= '0;
            bus.out_data <= '0;
        end else if (accept) begin
            sbuf[wr_ptr] <= bus.in_data;
            acc          <= '0;
            k            <= '0;
        end else if (state == MAC) begin
            acc <= acc_nx;
            k   <= last ? k : k + 1'b1;
            if (last) begin
                wr_ptr       <= wr_ptr == LAST_K ? '0 : wr_ptr + 1'b1;
                bus.out_data <= sat_out(acc_nx);
            end
        end
    end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed and randomized checks of fir_tap_sequencer against a direct-form FIR model.
// Define FIR_COEF_LOAD_EN to also exercise runtime coefficient loading.
module tb_fir_tap_sequencer;
    import fir_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    fir_tap_sequencer_if bus();
`ifdef FIR_COEF_LOAD_EN
    logic                 coef_we   = 1'b0;
    logic [4:0]           coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;
`endif

    fir_tap_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
`ifdef FIR_COEF_LOAD_EN
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    localparam int DEF [NTAPS] = '{0, -2639, -3331, 0, 6747, 13535, 16384, 13535, 6747, 0, -3331, -2639, 0, 0, 0, 0, 0};
    localparam int IMP [NTAPS] = '{0, -21, -26, 0, 52, 104, 127, 104, 52, 0, -26, -21, 0, 0, 0, 0, 0};

    int checks = 0, failures = 0, cyc = 0, rmode = 0;
    int hist[$], got[$], acc_edge[$], rise_edge[$];
    int mcoef [NTAPS];
    int exp_y = 0, cnt = 0;
    bit pending = 0, prev_rst = 0, prev_ov = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    // y[n] = sum coef[k]*x[n-k], clamped to 24 bits, floor-divided by 2^14.
    function automatic int model_y();
        longint s = 0;
        for (int i = 0; i < hist.size(); i++) s += longint'(mcoef[i]) * longint'(hist[i]);
        s = s > 8388607 ? 8388607 : (s < -8388608 ? -8388608 : s);
        return int'(s >>> 14);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : cmp
        bit hs_in, hs_out;
        if (!rst_n) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_out_data", $signed(bus.out_data), 0);
            hist.delete();
            pending = 0;
            cnt = 0;
            for (int i = 0; i < NTAPS; i++) mcoef[i] = DEF[i];
        end else begin
            chk("in_ready", bus.in_ready, prev_rst && !pending);
            chk("out_valid", bus.out_valid, pending && cnt == 0);
            chk("busy", busy, pending);
            if (pending && cnt == 0) chk("out_data", $signed(bus.out_data), exp_y);
            hs_out = pending && cnt == 0 && bus.out_ready;
            hs_in  = bus.in_valid && prev_rst && !pending;
            if (bus.out_valid && !prev_ov) rise_edge.push_back(cyc + 1);
            if (cnt > 0) cnt--;
`ifdef FIR_COEF_LOAD_EN
            if (coef_we && !pending && int'(coef_addr) < NTAPS) mcoef[coef_addr] = int'(coef_data);
`endif
            if (hs_out) begin
                got.push_back(int'($signed(bus.out_data)));
                pending = 0;
            end
            if (hs_in) begin
                hist.push_front(int'(bus.in_data));
                if (hist.size() > NTAPS) void'(hist.pop_back());
                exp_y = model_y();
                pending = 1;
                cnt = NTAPS;
                acc_edge.push_back(cyc + 1);
            end
        end
        prev_rst = rst_n;
        prev_ov  = bus.out_valid;
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rmode == 2 ? 1'b0 : (rmode == 1 ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    task automatic send(input int d, input int gap);
        int n = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(d);
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        int t = 0;
        while (got.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (got.size() < n) chk("output_timeout", got.size(), n);
        @(posedge clk);
        #1;
    endtask

    task automatic impulse(input string name);
        got.delete();
        send(127, 0);
        repeat (NTAPS - 1) send(0, 0);
        wait_outs(NTAPS);
        for (int i = 0; i < NTAPS; i++) chk(name, got[i], IMP[i]);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

`ifdef FIR_COEF_LOAD_EN
    task automatic wcoef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 5'(a);
        coef_data = CW'(d);
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        impulse("impulse");

        got.delete();
        repeat (NTAPS) send(127, 0);
        wait_outs(NTAPS);
        chk("step_pos", got[NTAPS-1], 348);
        got.delete();
        repeat (NTAPS) send(-128, 0);
        wait_outs(NTAPS);
        chk("step_neg", got[NTAPS-1], -352);

        begin : backpressure
            int t = 0;
            rmode = 2;
            got.delete();
            send(5, 0);
            while (!bus.out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            repeat (5) begin
                @(negedge clk);
                chk("bp_valid", bus.out_valid, 1);
                chk("bp_in_ready", bus.in_ready, 0);
                chk("bp_data", $signed(bus.out_data), -352);
            end
            rmode = 0;
            wait_outs(1);
            chk("bp_count", got.size(), 1);
            chk("bp_result", got[0], -352);
        end

        acc_edge.delete();
        rise_edge.delete();
        got.delete();
        send(0, 0);
        send(0, 0);
        wait_outs(2);
        chk("latency", rise_edge[0] - acc_edge[0], 18);
        chk("throughput", acc_edge[1] - acc_edge[0], 19);

        send(50, 0);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        impulse("impulse_after_reset");

`ifdef FIR_COEF_LOAD_EN
        for (int i = 0; i < NTAPS; i++) wcoef(i, 32'h7FFF);
        got.delete();
        repeat (NTAPS) send(127, 0);
        wait_outs(NTAPS);
        chk("sat_max", got[NTAPS-1], 511);
        got.delete();
        repeat (NTAPS) send(0, 0);
        wait_outs(NTAPS);
        chk("sat_zero", got[NTAPS-1], 0);
        got.delete();
        send(127, 0);
        wcoef(0, 0);
        wait_outs(1);
        chk("coef_write_in_mac", got[0], 253);
`endif

        pulse_reset();
        rmode = 1;
        got.delete();
        repeat (40) send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)));
        wait_outs(40);
        rmode = 0;

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule
